alu_core_mc: RTL and testbench

- Multi-cycle execution ALU for the uPOWER datapath.
- Consumes the 4-bit ALU_OP code produced by the ALU control unit, together with two operands.
- Returns the result and condition flags over a valid/ready handshake.
- Logic ops, add/sub and compare finish in one cycle. Shifts and multiply iterate, so the pipeline stalls on in_ready.

---
 rtl/alu_core_mc.sv | 171 +++++++++++++++++
 tb/tb_alu_core_mc.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/alu_core_mc.sv
// Multi-cycle execution ALU for the uPOWER datapath.
// One-cycle logic/arith ops; iterative shifts and shift-add multiply.
module alu_core_mc #(
  parameter int WIDTH = 64,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ALU_OP,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             illegal
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_NAND = 4'b1000;
  localparam logic [3:0] OP_NOR  = 4'b1001;
  localparam logic [3:0] OP_EXTS = 4'b1010;
  localparam logic [3:0] OP_MUL  = 4'b1011;
  localparam logic [3:0] OP_SRA  = 4'b1100;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q, acc_q;
  logic [SHW:0]     cnt_q;
  logic             rdy_q;

  logic [WIDTH-1:0] bb, ext, res_d;
  logic [WIDTH:0]   sum;
  logic             carry_d, ovf_d, ill_d;
  logic [SHW-1:0]   amt;
  logic             is_shift, is_mul, go_busy, accept, last;
  logic [WIDTH-1:0] sh_nxt, acc_nxt, busy_res;

  generate
    if (WIDTH > 32) begin : g_ext
      assign ext = {{(WIDTH-32){a[31]}}, a[31:0]};
    end else begin : g_noext
      assign ext = a;
    end
  endgenerate

  assign amt      = b[SHW-1:0];
  assign is_shift = (ALU_OP == OP_SLL) || (ALU_OP == OP_SRL) ||
                    (ALU_OP == OP_SRA);
  assign is_mul   = (ALU_OP == OP_MUL);
  assign go_busy  = is_mul || (is_shift && (amt != '0));
  assign in_ready = (state_q == IDLE) && rdy_q;
  assign accept   = in_ready && in_valid;
  assign out_valid = (state_q == DONE);
  assign last     = (cnt_q == (SHW+1)'(1));

  // SUB is a + ~b + 1 so carry reads as "no borrow"
  always_comb begin
    bb  = (ALU_OP == OP_SUB) ? ~b : b;
    sum = {1'b0, a} + {1'b0, bb} +
          (WIDTH+1)'(ALU_OP == OP_SUB);
    res_d   = '0;
    carry_d = 1'b0;
    ovf_d   = 1'b0;
    ill_d   = 1'b0;
    case (ALU_OP)
      OP_AND:  res_d = a & b;
      OP_OR:   res_d = a | b;
      OP_XOR:  res_d = a ^ b;
      OP_NAND: res_d = ~(a & b);
      OP_NOR:  res_d = ~(a | b);
      OP_EXTS: res_d = ext;
      OP_SLT:  res_d = {{(WIDTH-1){1'b0}},
                        ($signed(a) < $signed(b))};
      OP_ADD, OP_SUB: begin
        res_d   = sum[WIDTH-1:0];
        carry_d = sum[WIDTH];
        ovf_d   = (a[WIDTH-1] == bb[WIDTH-1]) &&
                  (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLL, OP_SRL, OP_SRA: res_d = a;
      OP_MUL:  res_d = '0;
      default: ill_d = 1'b1;
    endcase
  end

  always_comb begin
    case (op_q)
      OP_SLL:  sh_nxt = a_q << 1;
      OP_SRL:  sh_nxt = a_q >> 1;
      default: sh_nxt = {a_q[WIDTH-1], a_q[WIDTH-1:1]};
    endcase
    acc_nxt  = acc_q + (b_q[0] ? a_q : '0);
    busy_res = (op_q == OP_MUL) ? acc_nxt : sh_nxt;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = go_busy ? BUSY : DONE;
      BUSY: if (last) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result   <= '0;
      zero     <= 1'b0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      illegal  <= 1'b0;
    end else if (accept) begin
      op_q <= ALU_OP;
      a_q  <= a;
      b_q  <= b;
      if (go_busy) begin
        acc_q <= '0;
        cnt_q <= is_mul ? (SHW+1)'(WIDTH) : {1'b0, amt};
      end else begin
        result   <= res_d;
        zero     <= (res_d == '0);
        carry    <= carry_d;
        overflow <= ovf_d;
        illegal  <= ill_d;
      end
    end else if (state_q == BUSY) begin
      a_q   <= (op_q == OP_MUL) ? (a_q << 1) : sh_nxt;
      b_q   <= b_q >> 1;
      acc_q <= acc_nxt;
      cnt_q <= cnt_q - (SHW+1)'(1);
      if (last) begin
        result   <= busy_res;
        zero     <= (busy_res == '0);
        carry    <= 1'b0;
        overflow <= 1'b0;
        illegal  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_core_mc.sv
// Directed self-checking bench for alu_core_mc.
// Hand-computed vectors checked with immediate assertions.
module tb_alu_core_mc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  ALU_OP = '0;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] result;
  logic        zero, carry, overflow, illegal;

  int n_cmp = 0;
  int n_err = 0;
  int lat;
  logic [63:0] hold_res;
  logic [3:0]  hold_flg;

  alu_core_mc dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .ALU_OP(ALU_OP), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .carry(carry),
    .overflow(overflow), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [3:0] op,
                       input logic [63:0] av,
                       input logic [63:0] bv);
    int w = 0;
    while (!in_ready && w < 100) begin
      @(posedge clk); #1; w++;
    end
    chk("in_ready_before_start", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    ALU_OP = op; a = av; b = bv;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
  endtask

  task automatic wait_done();
    while (!out_valid && lat < 300) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic check_out(input string tag, input int exp_lat,
                           input logic [63:0] er,
                           input logic [3:0] ef);
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_res"}, result, er);
    chk({tag, "_flags_zcvi"},
        64'({zero, carry, overflow, illegal}), 64'(ef));
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_hs_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_hs_ready"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    #2;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", result, 64'd0);
    chk("rst_flags", 64'({zero, carry, overflow, illegal}), 64'd0);
    #10 rst_n = 1'b1;
    chk("rel_in_ready_early", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    chk("rel_in_ready", 64'(in_ready), 64'd1);

    start(4'b0010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
    wait_done();
    check_out("add_ovf", 1, 64'h8000_0000_0000_0000, 4'b0010);
    handshake("add_ovf");

    start(4'b1011, 64'h1234, 64'h5678);
    repeat (10) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", 64'(in_ready), 64'd0);
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_result", result, 64'd0);
    chk("abort_flags", 64'({zero, carry, overflow, illegal}), 64'd0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_rel_ready", 64'(in_ready), 64'd1);
    lat = 0;
    repeat (70) begin
      @(posedge clk); #1;
      if (out_valid) lat++;
    end
    chk("abort_no_stray_valid", 64'(lat), 64'd0);

    start(4'b0110, 64'd5, 64'd5);
    wait_done();
    check_out("sub_eq", 1, 64'd0, 4'b1100);
    handshake("sub_eq");

    start(4'b0100, 64'd1, 64'd63);
    wait_done();
    check_out("sll63", 64, 64'h8000_0000_0000_0000, 4'b0000);
    handshake("sll63");

    start(4'b1100, 64'h8000_0000_0000_0000, 64'd4);
    wait_done();
    check_out("sra4", 5, 64'hF800_0000_0000_0000, 4'b0000);
    handshake("sra4");

    start(4'b0101, 64'h8000_0000_0000_00F0, 64'h100);
    wait_done();
    check_out("srl0", 1, 64'h8000_0000_0000_00F0, 4'b0000);
    handshake("srl0");

    start(4'b1011, 64'h1_0000_0003, 64'h5);
    repeat (5) begin
      chk("mul_busy_ready", 64'(in_ready), 64'd0);
      chk("mul_busy_valid", 64'(out_valid), 64'd0);
      in_valid = 1'b1;
      ALU_OP = 4'b0010; a = 64'd9; b = 64'd9;
      @(posedge clk); #1; lat++;
    end
    in_valid = 1'b0;
    wait_done();
    check_out("mul", 65, 64'h5_0000_000F, 4'b0000);
    handshake("mul");

    start(4'b0011, 64'hF0F0, 64'hFF00);
    wait_done();
    check_out("xor", 1, 64'h0FF0, 4'b0000);
    hold_res = result;
    hold_flg = {zero, carry, overflow, illegal};
    repeat (7) begin
      @(posedge clk); #1;
      chk("bp_result", result, hold_res);
      chk("bp_flags", 64'({zero, carry, overflow, illegal}),
          64'(hold_flg));
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
    end
    handshake("xor_bp");

    start(4'b1110, 64'hDEAD_BEEF, 64'h1234);
    wait_done();
    check_out("illegal", 1, 64'd0, 4'b1001);
    handshake("illegal");

    start(4'b0111, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1);
    wait_done();
    check_out("slt", 1, 64'd1, 4'b0000);
    handshake("slt");

    start(4'b1010, 64'h8000_0000, 64'd0);
    wait_done();
    check_out("extsw", 1, 64'hFFFF_FFFF_8000_0000, 4'b0000);
    handshake("extsw");

    start(4'b1001, 64'hFFFF_0000_FFFF_0000, 64'h0000_FFFF_0000_FFFF);
    wait_done();
    check_out("nor", 1, 64'd0, 4'b1000);
    handshake("nor");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
